// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I control path: opcodes, FSM states, ALU codes, mux selects.
// No logic, so no latency.
// No flow control; constants only.
package riscv_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Multi-cycle controller states; codes 11-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  // Main-decoder to ALU-decoder operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU A-operand mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU B-operand mux
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from operation class and instruction function fields.
// Purely combinational, zero latency.
// No flow control.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // op5 separates R-type from I-type, so addi with imm[10]=1 is never mistaken for sub
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: drives datapath enables/selects from state, counts retirements.
// lw 5, sw 4, R/I 4, jal 4, beq 3 cycles with mem_ready held high.
// Stalls in FETCH (if FETCH_WAIT), MEMREAD and MEMWRITE until mem_ready.
module multicycle_control_fsm
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit FETCH_WAIT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pcwrite,
  output logic            adrsrc,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regwrite,
  output logic [1:0]      resultsrc,
  output logic [1:0]      alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      immsrc,
  output logic [2:0]      alucontrol,
  output logic            illegal,
  output logic [3:0]      state_o,
  output logic [XLEN-1:0] instret
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic [1:0]      aluop;
  logic            retire;
  logic            pcwrite_raw, irwrite_raw, memwrite_raw, regwrite_raw;

  // State and retirement counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_d      = S_FETCH;
    pcwrite_raw  = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = RES_ALUOUT;
    alusrca      = SRCA_PC;
    alusrcb      = SRCB_RD2;
    aluop        = ALUOP_ADD;
    illegal      = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb     = SRCB_FOUR;
        resultsrc   = RES_ALU;
        irwrite_raw = mem_ready;
        pcwrite_raw = mem_ready;
        state_d     = (FETCH_WAIT && !mem_ready) ? S_FETCH : S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch/jump target into ALUOut while decoding
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultsrc    = RES_DATA;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        retire       = mem_ready;
        state_d      = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_RD2;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        resultsrc    = RES_ALUOUT;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
      end
      S_JAL: begin
        // PC <- target already in ALUOut; ALU forms OldPC+4 for the link write
        alusrca     = SRCA_OLDPC;
        alusrcb     = SRCB_FOUR;
        resultsrc   = RES_ALUOUT;
        pcwrite_raw = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BEQ: begin
        alusrca     = SRCA_RD1;
        alusrcb     = SRCB_RD2;
        aluop       = ALUOP_SUB;
        resultsrc   = RES_ALUOUT;
        pcwrite_raw = zero;
        retire      = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + {{(XLEN-1){1'b0}}, retire};
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

  // Architectural strobes are suppressed while reset is low so an aborted op has no side effect
  assign pcwrite  = pcwrite_raw  & reset;
  assign irwrite  = irwrite_raw  & reset;
  assign memwrite = memwrite_raw & reset;
  assign regwrite = regwrite_raw & reset;
  assign state_o  = state_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0]  resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state_o;
  logic [31:0] instret;

  // Narrow-counter twin, same stimulus, used to observe counter wrap
  logic        w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite, w_illegal;
  logic [1:0]  w_resultsrc, w_alusrca, w_alusrcb, w_immsrc;
  logic [2:0]  w_alucontrol;
  logic [3:0]  w_state_o;
  logic [3:0]  w_instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = '0;

  multicycle_control_fsm #(.XLEN(32), .FETCH_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state_o(state_o), .instret(instret)
  );

  multicycle_control_fsm #(.XLEN(4), .FETCH_WAIT(1'b1)) dut_w (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(w_pcwrite), .adrsrc(w_adrsrc),
    .memwrite(w_memwrite), .irwrite(w_irwrite), .regwrite(w_regwrite),
    .resultsrc(w_resultsrc), .alusrca(w_alusrca), .alusrcb(w_alusrcb), .immsrc(w_immsrc),
    .alucontrol(w_alucontrol), .illegal(w_illegal), .state_o(w_state_o), .instret(w_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state_o !== 4'd0 || instret !== 32'd0 || w_instret !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d state=%0d instret=%0d w=%0d exp 0/0/0", i, state_o, instret, w_instret);
      end
      checks++;
      if ({pcwrite, irwrite, memwrite, regwrite} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_strobes cyc=%0d got %b exp 0000", i, {pcwrite, irwrite, memwrite, regwrite});
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (irwrite !== 1'b1 || pcwrite !== 1'b1 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_release irwrite=%b pcwrite=%b state=%0d exp 1 1 0", irwrite, pcwrite, state_o);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    op = OP_LW; funct3 = 3'b010; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state_o !== seq[i] || regwrite !== (seq[i] == 4'd4)) begin
        errors++;
        $display("FAIL lw_step i=%0d state=%0d regwrite=%b exp state %0d", i, state_o, regwrite, seq[i]);
      end
      if (seq[i] == 4'd4) begin
        checks++;
        if (resultsrc !== 2'b01) begin
          errors++;
          $display("FAIL lw_resultsrc got %b exp 01", resultsrc);
        end
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (state_o !== 4'd0 || instret !== exp_ret) begin
      errors++;
      $display("FAIL lw_retire state=%0d instret=%0d exp 0 %0d", state_o, instret, exp_ret);
    end
  endtask

  task automatic test_sw_stall();
    op = OP_SW; funct3 = 3'b010; mem_ready = 1'b1;
    #1;
    checks++;
    if (immsrc !== 2'b01) begin
      errors++;
      $display("FAIL sw_immsrc got %b exp 01", immsrc);
    end
    tick(); tick();
    checks++;
    if (state_o !== 4'd2 || alusrca !== 2'b10 || alusrcb !== 2'b01) begin
      errors++;
      $display("FAIL sw_memadr state=%0d srca=%b srcb=%b exp 2 10 01", state_o, alusrca, alusrcb);
    end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      checks++;
      if (state_o !== 4'd5 || memwrite !== 1'b1 || adrsrc !== 1'b1 || instret !== exp_ret) begin
        errors++;
        $display("FAIL sw_hold i=%0d state=%0d memwrite=%b adrsrc=%b instret=%0d exp 5 1 1 %0d",
                 i, state_o, memwrite, adrsrc, instret, exp_ret);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (state_o !== 4'd0 || memwrite !== 1'b0 || instret !== exp_ret) begin
      errors++;
      $display("FAIL sw_retire state=%0d memwrite=%b instret=%0d exp 0 0 %0d", state_o, memwrite, instret, exp_ret);
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] t_op [5];
    logic [2:0] t_f3 [5];
    logic       t_f7 [5];
    logic [2:0] t_exp [5];
    t_op  = '{OP_R,   OP_I,   OP_R,   OP_R,   OP_I};
    t_f3  = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
    t_f7  = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0};
    t_exp = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b101};
    for (int i = 0; i < 5; i++) begin
      op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i];
      #1;
      checks++;
      if (alucontrol !== 3'b000 || alusrcb !== 2'b10) begin
        errors++;
        $display("FAIL alu_fetch i=%0d alucontrol=%b srcb=%b exp 000 10", i, alucontrol, alusrcb);
      end
      tick(); tick();
      checks++;
      if (state_o !== ((op == OP_R) ? 4'd6 : 4'd8) || alucontrol !== t_exp[i] || alusrca !== 2'b10 ||
          alusrcb !== ((op == OP_R) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL alu_exec i=%0d state=%0d alucontrol=%b srca=%b srcb=%b exp alucontrol %b",
                 i, state_o, alucontrol, alusrca, alusrcb, t_exp[i]);
      end
      tick();
      checks++;
      if (state_o !== 4'd7 || regwrite !== 1'b1 || resultsrc !== 2'b00) begin
        errors++;
        $display("FAIL alu_wb i=%0d state=%0d regwrite=%b resultsrc=%b exp 7 1 00", i, state_o, regwrite, resultsrc);
      end
      tick();
      exp_ret++;
      checks++;
      if (state_o !== 4'd0 || instret !== exp_ret) begin
        errors++;
        $display("FAIL alu_retire i=%0d state=%0d instret=%0d exp 0 %0d", i, state_o, instret, exp_ret);
      end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      op = OP_BEQ; zero = (z == 1);
      #1;
      checks++;
      if (immsrc !== 2'b10) begin
        errors++;
        $display("FAIL beq_immsrc got %b exp 10", immsrc);
      end
      tick();
      checks++;
      if (state_o !== 4'd1 || alusrca !== 2'b01 || alusrcb !== 2'b01) begin
        errors++;
        $display("FAIL beq_decode state=%0d srca=%b srcb=%b exp 1 01 01", state_o, alusrca, alusrcb);
      end
      tick();
      checks++;
      if (state_o !== 4'd10 || pcwrite !== (z == 1) || alucontrol !== 3'b001 || regwrite !== 1'b0) begin
        errors++;
        $display("FAIL beq_exec zero=%0d state=%0d pcwrite=%b alucontrol=%b regwrite=%b exp 10 %0d 001 0",
                 z, state_o, pcwrite, alucontrol, regwrite, z);
      end
      tick();
      exp_ret++;
      checks++;
      if (state_o !== 4'd0 || instret !== exp_ret) begin
        errors++;
        $display("FAIL beq_retire zero=%0d state=%0d instret=%0d exp 0 %0d", z, state_o, instret, exp_ret);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    op = OP_JAL;
    #1;
    checks++;
    if (immsrc !== 2'b11) begin
      errors++;
      $display("FAIL jal_immsrc got %b exp 11", immsrc);
    end
    tick(); tick();
    checks++;
    if (state_o !== 4'd9 || pcwrite !== 1'b1 || alusrca !== 2'b01 || alusrcb !== 2'b10 || resultsrc !== 2'b00) begin
      errors++;
      $display("FAIL jal_exec state=%0d pcwrite=%b srca=%b srcb=%b res=%b exp 9 1 01 10 00",
               state_o, pcwrite, alusrca, alusrcb, resultsrc);
    end
    tick();
    checks++;
    if (state_o !== 4'd7 || instret !== exp_ret) begin
      errors++;
      $display("FAIL jal_wb state=%0d instret=%0d exp 7 %0d", state_o, instret, exp_ret);
    end
    tick();
    exp_ret++;
    checks++;
    if (state_o !== 4'd0 || instret !== exp_ret) begin
      errors++;
      $display("FAIL jal_retire state=%0d instret=%0d exp 0 %0d", state_o, instret, exp_ret);
    end
  endtask

  task automatic test_illegal();
    op = OP_BAD;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_fetch got %b exp 0", illegal);
    end
    tick();
    checks++;
    if (state_o !== 4'd1 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_decode state=%0d illegal=%b exp 1 1", state_o, illegal);
    end
    tick();
    checks++;
    if (state_o !== 4'd0 || illegal !== 1'b0 || instret !== exp_ret) begin
      errors++;
      $display("FAIL illegal_after state=%0d illegal=%b instret=%0d exp 0 0 %0d", state_o, illegal, instret, exp_ret);
    end
  endtask

  task automatic test_fetch_stall();
    mem_ready = 1'b0; op = OP_BAD;
    #1;
    checks++;
    if (irwrite !== 1'b0 || pcwrite !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall_strobes irwrite=%b pcwrite=%b exp 0 0", irwrite, pcwrite);
    end
    tick();
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL fetch_stall_hold state=%0d exp 0", state_o);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (state_o !== 4'd1) begin
      errors++;
      $display("FAIL fetch_stall_go state=%0d exp 1", state_o);
    end
    tick();
  endtask

  task automatic test_wrap();
    op = OP_BEQ; zero = 1'b0;
    while (exp_ret < 32'd16) begin
      tick(); tick(); tick();
      exp_ret++;
      checks++;
      if (w_instret !== exp_ret[3:0] || instret !== exp_ret) begin
        errors++;
        $display("FAIL wrap_count narrow=%0d wide=%0d exp %0d %0d", w_instret, instret, exp_ret[3:0], exp_ret);
      end
    end
    checks++;
    if (w_instret !== 4'd0) begin
      errors++;
      $display("FAIL wrap_zero got %0d exp 0", w_instret);
    end
  endtask

  task automatic test_reset_abort();
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (state_o !== 4'd7 || regwrite !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup state=%0d regwrite=%b exp 7 1", state_o, regwrite);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (regwrite !== 1'b0 || pcwrite !== 1'b0 || irwrite !== 1'b0 || state_o !== 4'd0 || instret !== 32'd0) begin
      errors++;
      $display("FAIL abort_now regwrite=%b pcwrite=%b irwrite=%b state=%0d instret=%0d exp 0 0 0 0 0",
               regwrite, pcwrite, irwrite, state_o, instret);
    end
    tick();
    checks++;
    if (instret !== 32'd0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL abort_held instret=%0d state=%0d exp 0 0", instret, state_o);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu_decode();
    test_beq();
    test_jal();
    test_illegal();
    test_fetch_stall();
    test_wrap();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
